sa3x3_result_collector: RTL and testbench
=========================================

// Module: sa3x3_result_collector
// PURPOSE
//  Receive end of the 3x3 systolic-array convolution datapath. Captures the three column
//  partial sums (psum_out1..3) on each capture strobe from the conv controller and
//  de-skews them with per-column delay lines. Adds the three columns and tags each sum
//  with its output position (11,12,21,22). Buffers results in a FIFO and streams them
//  to a downstream consumer over a valid/ready handshake.
// PARAMETERS
//  SKEW   0  cycles between adjacent column results; col1 delayed 2*SKEW, col2 SKEW, col3 0
//  DEPTH  4  FIFO entries; power of two, >=2
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  frame_start  in   1   1-cycle pulse: new 2x2 output frame begins
//  cap_valid    in   1   capture strobe (controller's reg_enable_xx OR'd)
//  psum_in1     in   8   column-1 partial sum from array
//  psum_in2     in   8   column-2 partial sum
//  psum_in3     in   8   column-3 partial sum
//  out_valid    out  1   FIFO head valid
//  out_ready    in   1   consumer accepts head this cycle
//  out_data     out  8   conv result at FIFO head
//  out_idx      out  2   position of head: 0=11,1=12,2=21,3=22
//  out_last     out  1   out_idx==3 (last result of frame)
//  frame_done   out  1   1-cycle pulse after idx-3 result is pushed
//  overflow     out  1   sticky: a capture was dropped because FIFO full
//  count        out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_idx=0, out_last=0, frame_done=0, overflow=0, count=0.
//   Delay lines, FIFO pointers and position counter are zeroed.
//  Reset mid-operation discards FIFO contents and in-flight delay-line data immediately.
//  De-skew: delay lines shift every cycle regardless of cap_valid. With SKEW=0 all
//   columns are taken combinationally in the strobe cycle.
//  Sum = (c1 + c2 + c3) mod 256 (8-bit unsigned wrap, carries discarded).
//  Push: on edge where cap_valid=1, {pos_cnt, sum} written at wr_ptr. pos_cnt increments
//   and wraps 3->0. On pushing pos 3, frame_done=1 for the next cycle only.
//  Pop: on edge where out_valid & out_ready, rd_ptr advances.
//   out_data/out_idx are undefined-free: they hold 0 when empty.
//  Latency: capture at edge t -> out_valid=1 in cycle t+1 if FIFO was empty.
//   There is no combinational path from cap_valid to out_valid.
//  Full: cap_valid while count==DEPTH and no pop this cycle -> data dropped.
//   overflow<=1, pos_cnt still increments so later tags remain positional.
//  Simultaneous push+pop when full: both accepted, count unchanged, no overflow.
//  Simultaneous push+pop when empty: push accepted, pop ignored (out_valid was 0).
//  Pointers wrap modulo DEPTH; count distinguishes full from empty.
//  frame_start: pos_cnt<=0, overflow<=0; FIFO contents are not flushed.
//   If cap_valid is in the same cycle, the capture is tagged pos 0, then pos_cnt<=1.
//  out_valid, once high, stays high with stable out_data/out_idx until popped
//   (AXI-style; no retraction).
//  States of pos_cnt: P0->P1->P2->P3->P0 on each cap_valid. frame_start forces P0.
// TESTING
//  1 SKEW=0; frame_start, then 4 strobes with (1,2,3),(4,5,6),(7,8,9),(10,20,30), out_ready=1
//    -> outputs 6/idx0, 15/idx1, 24/idx2, 60/idx3 with out_last=1; frame_done pulses once.
//  2 Wrap: strobe with (200,100,1) -> out_data=45.
//  3 out_ready=0; 5 strobes with DEPTH=4 -> count=4, overflow=1, 5th value absent.
//    Release ready -> the 4 stored values drain in order, then out_valid=0.
//  4 Full FIFO + cap_valid + out_ready in the same cycle -> head popped, new value pushed,
//    count stays 4, overflow stays 0.
//  5 SKEW=1; col1=5 at t-2, col2=6 at t-1, col3=7 at t with strobe at t -> out_data=18.
//  6 Assert rst while count=3 and out_valid=1 -> next cycle out_valid=0, count=0, idx=0.

Source files
------------

// File: rtl/sa3x3_result_collector.sv
// sa3x3_result_collector
// Receive end of the 3x3 systolic-array convolution datapath. Column partial
// sums are de-skewed, added into an 8-bit wrapped result and tagged with their
// output position (11,12,21,22), then queued in a small FIFO that streams to a
// valid/ready consumer. The FIFO is fall-through-free: a capture on edge t is
// visible at the head in cycle t+1 at the earliest.

// ---------------------------------------------------------------------------
// sa3x3_delay_line
// Fixed-length shift register. It advances every cycle and ignores the
// capture strobe, so each column stays aligned to the array's skew.
// ---------------------------------------------------------------------------
module sa3x3_delay_line #(
   parameter int W = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [D];

   // Shift chain; reset flushes any in-flight column data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[D-1];

endmodule

// ---------------------------------------------------------------------------
// sa3x3_pos_fsm
// Output-position tracker for one 2x2 frame.
//
//   state | meaning
//   ------+---------------------------------------------
//   P0    | next capture is output position 11 (idx 0)
//   P1    | next capture is output position 12 (idx 1)
//   P2    | next capture is output position 21 (idx 2)
//   P3    | next capture is output position 22 (idx 3)
//
// Every capture advances the position, including one the FIFO drops, so the
// tags on later results stay positional. frame_start forces P0 and also tags
// a capture arriving in the same cycle as P0.
// ---------------------------------------------------------------------------
module sa3x3_pos_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       cap_valid,
   output logic [1:0] cur_pos
);

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } pos_t;

   pos_t state_q;
   pos_t state_eff;
   pos_t state_nxt;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= P0;
      else     state_q <= state_nxt;
   end

   // Next-state logic. frame_start takes priority and selects the current tag.
   always_comb begin
      state_eff = state_q;
      state_nxt = state_q;
      if (frame_start) begin
         state_eff = P0;
         state_nxt = P0;
      end
      if (cap_valid) begin
         unique case (state_eff)
            P0: state_nxt = P1;
            P1: state_nxt = P2;
            P2: state_nxt = P3;
            P3: state_nxt = P0;
            default: state_nxt = P0;
         endcase
      end
   end

   assign cur_pos = state_eff;

endmodule

// ---------------------------------------------------------------------------
// sa3x3_result_collector (top)
// ---------------------------------------------------------------------------
module sa3x3_result_collector #(
   parameter int SKEW  = 0,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_start,
   input  logic                     cap_valid,
   input  logic [7:0]               psum_in1,
   input  logic [7:0]               psum_in2,
   input  logic [7:0]               psum_in3,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_data,
   output logic [1:0]               out_idx,
   output logic                     out_last,
   output logic                     frame_done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int D1 = 2 * SKEW;
   localparam int D2 = SKEW;

   logic [7:0]    col1;
   logic [7:0]    col2;
   logic [7:0]    col3;
   logic [7:0]    sum;
   logic [1:0]    cur_pos;

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          frame_done_q;
   logic          overflow_q;

   // Column 1 leads the array by two skews, column 2 by one; column 3 is the
   // reference and is always taken straight from the strobe cycle.
   generate
      if (D1 == 0) begin : g_col1_direct
         assign col1 = psum_in1;
      end else begin : g_col1_dly
         sa3x3_delay_line #(.W(8), .D(D1)) u_dly1 (
            .clk  (clk),
            .rst  (rst),
            .din  (psum_in1),
            .dout (col1)
         );
      end

      if (D2 == 0) begin : g_col2_direct
         assign col2 = psum_in2;
      end else begin : g_col2_dly
         sa3x3_delay_line #(.W(8), .D(D2)) u_dly2 (
            .clk  (clk),
            .rst  (rst),
            .din  (psum_in2),
            .dout (col2)
         );
      end
   endgenerate

   assign col3 = psum_in3;

   // 8-bit wrap: carries out of the adder are deliberately discarded.
   assign sum = col1 + col2 + col3;

   sa3x3_pos_fsm u_pos (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .cap_valid   (cap_valid),
      .cur_pos     (cur_pos)
   );

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign pop   = ~empty & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = cap_valid & (~full | pop);

   // Result storage: {position tag, sum}.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= {cur_pos, sum};
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); occupancy tracks full/empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Frame completion pulse and sticky drop flag. A drop in the same cycle as
   // frame_start wins, since that capture belongs to the new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         frame_done_q <= push & (cur_pos == 2'd3);
         if (cap_valid & ~push) overflow_q <= 1'b1;
         else if (frame_start)  overflow_q <= 1'b0;
      end
   end

   assign out_valid  = ~empty;
   assign out_data   = empty ? 8'd0 : mem[rd_ptr][7:0];
   assign out_idx    = empty ? 2'd0 : mem[rd_ptr][9:8];
   assign out_last   = ~empty & (mem[rd_ptr][9:8] == 2'd3);
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign count      = count_q;

endmodule

// File: tb/tb_sa3x3_result_collector.sv
// Directed bench for sa3x3_result_collector. A SKEW=0 instance carries most
// checks; a SKEW=1 instance on the same stimulus covers column de-skew.
module tb_sa3x3_result_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic       cap_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] psum_in1 = 8'd0;
   logic [7:0] psum_in2 = 8'd0;
   logic [7:0] psum_in3 = 8'd0;

   logic       out_valid, out_last, frame_done, overflow;
   logic [7:0] out_data;
   logic [1:0] out_idx;
   logic [2:0] count;

   logic       s1_out_valid, s1_out_last, s1_frame_done, s1_overflow;
   logic [7:0] s1_out_data;
   logic [1:0] s1_out_idx;
   logic [2:0] s1_count;

   int n_vec  = 0;
   int n_miss = 0;

   sa3x3_result_collector #(.SKEW(0), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .cap_valid   (cap_valid),
      .psum_in1    (psum_in1),
      .psum_in2    (psum_in2),
      .psum_in3    (psum_in3),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_idx     (out_idx),
      .out_last    (out_last),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .count       (count)
   );

   sa3x3_result_collector #(.SKEW(1), .DEPTH(4)) dut_s1 (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .cap_valid   (cap_valid),
      .psum_in1    (psum_in1),
      .psum_in2    (psum_in2),
      .psum_in3    (psum_in3),
      .out_valid   (s1_out_valid),
      .out_ready   (out_ready),
      .out_data    (s1_out_data),
      .out_idx     (s1_out_idx),
      .out_last    (s1_out_last),
      .frame_done  (s1_frame_done),
      .overflow    (s1_overflow),
      .count       (s1_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic fs, input logic cv, input logic rdy,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      frame_start = fs;
      cap_valid   = cv;
      out_ready   = rdy;
      psum_in1    = a;
      psum_in2    = b;
      psum_in3    = c;
   endtask

   task automatic do_reset();
      drv(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // reset state
      chk("rst_valid", out_valid, 0);
      chk("rst_data",  out_data, 0);
      chk("rst_idx",   out_idx, 0);
      chk("rst_last",  out_last, 0);
      chk("rst_fdone", frame_done, 0);
      chk("rst_ovf",   overflow, 0);
      chk("rst_count", count, 0);

      // 1: one frame, consumer always ready
      drv(1, 0, 1, 0, 0, 0); tick();
      drv(0, 1, 1, 1, 2, 3); tick();
      chk("t1_valid0", out_valid, 1);
      chk("t1_data0",  out_data, 6);
      chk("t1_idx0",   out_idx, 0);
      chk("t1_last0",  out_last, 0);
      drv(0, 1, 1, 4, 5, 6); tick();
      chk("t1_data1",  out_data, 15);
      chk("t1_idx1",   out_idx, 1);
      drv(0, 1, 1, 7, 8, 9); tick();
      chk("t1_data2",  out_data, 24);
      chk("t1_idx2",   out_idx, 2);
      chk("t1_fdone2", frame_done, 0);
      drv(0, 1, 1, 10, 20, 30); tick();
      chk("t1_data3",  out_data, 60);
      chk("t1_idx3",   out_idx, 3);
      chk("t1_last3",  out_last, 1);
      chk("t1_fdone3", frame_done, 1);
      drv(0, 0, 1, 0, 0, 0); tick();
      chk("t1_drained", out_valid, 0);
      chk("t1_fdone_end", frame_done, 0);
      chk("t1_data_empty", out_data, 0);
      chk("t1_count_end", count, 0);

      // 2: 8-bit wrap, 200+100+1 = 301 -> 45
      drv(0, 1, 1, 200, 100, 1); tick();
      chk("t2_wrap", out_data, 45);
      chk("t2_idx",  out_idx, 0);
      drv(0, 0, 1, 0, 0, 0); tick();
      chk("t2_empty", out_valid, 0);

      // 3: overflow with consumer stalled, then drain in order
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         drv(0, 1, 0, 8'(i), 0, 0); tick();
         if (i == 4) begin
            chk("t3_count4", count, 4);
            chk("t3_ovf4", overflow, 0);
         end
      end
      chk("t3_count5", count, 4);
      chk("t3_ovf5",   overflow, 1);
      drv(0, 0, 1, 0, 0, 0);
      chk("t3_head1",  out_data, 1);
      chk("t3_hidx1",  out_idx, 0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("t3_head", out_data, k);
         chk("t3_hidx", out_idx, k - 1);
      end
      tick();
      chk("t3_empty",  out_valid, 0);
      chk("t3_count0", count, 0);

      // 4: full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drv(0, 1, 0, 8'(10 * i), 0, 0); tick();
      end
      chk("t4_full", count, 4);
      drv(0, 1, 1, 50, 0, 0); tick();
      chk("t4_count", count, 4);
      chk("t4_ovf",   overflow, 0);
      chk("t4_head",  out_data, 20);
      drv(0, 0, 1, 0, 0, 0);
      tick(); chk("t4_d30", out_data, 30);
      tick(); chk("t4_d40", out_data, 40);
      tick(); chk("t4_d50", out_data, 50);
      chk("t4_i50", out_idx, 0);
      tick(); chk("t4_empty", out_valid, 0);

      // 5: SKEW=1 de-skew, col1 at t-2, col2 at t-1, col3 at t
      do_reset();
      drv(0, 0, 0, 5, 0, 0); tick();
      drv(0, 0, 0, 0, 6, 0); tick();
      drv(0, 1, 0, 0, 0, 7); tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("t5_s1_data",  s1_out_data, 18);
      chk("t5_s1_idx",   s1_out_idx, 0);
      chk("t5_s1_valid", s1_out_valid, 1);
      chk("t5_s1_count", s1_count, 1);
      chk("t5_s1_last",  s1_out_last, 0);
      chk("t5_s1_fdone", s1_frame_done, 0);
      chk("t5_s1_ovf",   s1_overflow, 0);

      // 6: reset with results queued
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         drv(0, 1, 0, 8'(i), 0, 0); tick();
      end
      drv(0, 0, 0, 0, 0, 0);
      chk("t6_count3", count, 3);
      chk("t6_valid",  out_valid, 1);
      rst = 1'b1;
      #1;
      chk("t6_async_count", count, 0);
      tick();
      chk("t6_valid0", out_valid, 0);
      chk("t6_count0", count, 0);
      chk("t6_idx0",   out_idx, 0);
      rst = 1'b0;

      // 7: frame_start coincident with a capture retags it to position 0
      do_reset();
      drv(0, 1, 0, 1, 0, 0); tick();
      drv(0, 1, 0, 2, 0, 0); tick();
      drv(1, 1, 0, 3, 0, 0); tick();
      drv(0, 1, 0, 4, 0, 0); tick();
      chk("t7_count", count, 4);
      drv(0, 0, 1, 0, 0, 0);
      chk("t7_d1", out_data, 1); chk("t7_i1", out_idx, 0);
      tick(); chk("t7_d2", out_data, 2); chk("t7_i2", out_idx, 1);
      tick(); chk("t7_d3", out_data, 3); chk("t7_i3", out_idx, 0);
      tick(); chk("t7_d4", out_data, 4); chk("t7_i4", out_idx, 1);
      tick(); chk("t7_empty", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
